// File: rtl/wb_uart_arbiter_if.sv
// wb_uart_arbiter_if: one Wishbone link (request, write data, read data, ack, err).
interface wb_uart_arbiter_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0] sel;
  logic we;
  logic cyc;
  logic stb;
  logic ack;
  logic err;
  modport master (output adr, wdat, sel, we, cyc, stb, input rdat, ack, err);
  modport slave (input adr, wdat, sel, we, cyc, stb, output rdat, ack, err);
endinterface

// File: rtl/wb_uart_arbiter.sv
// wb_uart_arbiter: round-robin two-master Wishbone arbiter in front of the UART slave.
// Define UART_ARB_WATCHDOG_EN to build the stalled-strobe watchdog.
module wb_uart_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk_i,
  input logic rst,
  wb_uart_arbiter_if.slave m0,
  wb_uart_arbiter_if.slave m1,
  wb_uart_arbiter_if.master s
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nx;
  logic last, own0, own1, ostb, fire;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  always_ff @(posedge clk_i or posedge rst)
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
    end else begin
      state <= state_nx;
      if (state != IDLE && state_nx == IDLE) last <= own1;
    end
  // Tenures always end in IDLE, so the other master waits at least one idle cycle.
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = (m0.cyc && (!m1.cyc || last)) ? OWN0 : m1.cyc ? OWN1 : IDLE;
    else if (own0)
      state_nx = m0.cyc ? OWN0 : IDLE;
    else
      state_nx = m1.cyc ? OWN1 : IDLE;
  end
  assign ostb = own0 ? m0.stb : own1 ? m1.stb : 1'b0;
  assign s.adr = own0 ? m0.adr : own1 ? m1.adr : '0;
  assign s.wdat = own0 ? m0.wdat : own1 ? m1.wdat : '0;
  assign s.sel = own0 ? m0.sel : own1 ? m1.sel : '0;
  assign s.we = own0 ? m0.we : own1 ? m1.we : 1'b0;
  assign s.cyc = own0 ? m0.cyc : own1 ? m1.cyc : 1'b0;
  assign s.stb = ostb & ~fire;
  assign m0.ack = own0 & s.ack;
  assign m1.ack = own1 & s.ack;
  assign m0.rdat = own0 ? s.rdat : '0;
  assign m1.rdat = own1 ? s.rdat : '0;
  assign m0.err = own0 & fire;
  assign m1.err = own1 & fire;
`ifdef UART_ARB_WATCHDOG_EN
  logic stall;
  logic [15:0] cnt;
  assign stall = ostb & ~s.ack;
  // fire lands on the TIMEOUT_CYCLES-th consecutive stalled cycle
  assign fire = stall && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (stall && !fire) ? cnt + 16'd1 : '0;
`else
  assign fire = 1'b0;
`endif
endmodule

// File: tb/tb_wb_uart_arbiter.sv
// tb_wb_uart_arbiter: table-driven checks of grant, routing, fairness, reset and watchdog behaviour.
module tb_wb_uart_arbiter;
  typedef logic [138:0] bus_t;
  typedef struct {
    logic c0, s0, w0, c1, s1, w1, ack;
    logic [31:0] sdat;
    int own;
  } vec_t;
  localparam logic [31:0] A0 = 32'h1000_0004;
  localparam logic [31:0] A1 = 32'h1000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int nbad = 0;
  vec_t tv[18];
  wb_uart_arbiter_if m0 ();
  wb_uart_arbiter_if m1 ();
  wb_uart_arbiter_if s ();
  wb_uart_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk_i(clk), .rst(rst), .m0(m0), .m1(m1), .s(s));
  always #5 clk = ~clk;
  function automatic bus_t model(input int own, input logic e0, input logic e1);
    logic c, st, w;
    logic [31:0] a, d;
    logic [3:0] se;
    c = own == 1 ? m0.cyc : own == 2 ? m1.cyc : 1'b0;
    st = own == 1 ? m0.stb : own == 2 ? m1.stb : 1'b0;
    w = own == 1 ? m0.we : own == 2 ? m1.we : 1'b0;
    a = own == 1 ? A0 : own == 2 ? A1 : 32'h0;
    d = own == 1 ? 32'h11 : own == 2 ? 32'h55 : 32'h0;
    se = own == 1 ? 4'h1 : own == 2 ? 4'h2 : 4'h0;
    return {c, st & ~(e0 | e1), w, a, d, se,
            own == 1 && s.ack, e0, own == 1 ? s.rdat : 32'h0,
            own == 2 && s.ack, e1, own == 2 ? s.rdat : 32'h0};
  endfunction
  task automatic drv(input logic c0, s0, w0, c1, s1, w1, ack, input logic [31:0] sdat);
    m0.cyc = c0; m0.stb = s0; m0.we = w0;
    m1.cyc = c1; m1.stb = s1; m1.we = w1;
    s.ack = ack; s.rdat = sdat;
  endtask
  task automatic chk(input string name, input int own, input logic e0, input logic e1);
    bus_t act, exp;
    act = {s.cyc, s.stb, s.we, s.adr, s.wdat, s.sel, m0.ack, m0.err, m0.rdat, m1.ack, m1.err, m1.rdat};
    exp = model(own, e0, e1);
    n++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    tv[0] = '{1, 1, 0, 0, 0, 0, 1, 32'h41, 1};
    tv[1] = '{0, 0, 0, 0, 0, 0, 0, 32'h0, 1};
    tv[2] = '{1, 1, 0, 1, 1, 0, 1, 32'h99, 0};
    tv[3] = '{1, 1, 0, 1, 1, 1, 0, 32'h0, 2};
    tv[4] = '{1, 1, 0, 1, 1, 1, 1, 32'h0, 2};
    tv[5] = '{1, 1, 0, 1, 0, 0, 0, 32'h0, 2};
    tv[6] = '{1, 1, 0, 1, 1, 0, 1, 32'h7A, 2};
    tv[7] = '{1, 1, 0, 1, 1, 1, 1, 32'h0, 2};
    tv[8] = '{1, 1, 0, 0, 0, 0, 0, 32'h0, 2};
    tv[9] = '{1, 1, 0, 1, 1, 0, 1, 32'h12, 0};
    tv[10] = '{1, 1, 1, 1, 1, 0, 1, 32'h34, 1};
    tv[11] = '{0, 0, 0, 1, 1, 0, 0, 32'h0, 1};
    tv[12] = '{1, 1, 0, 1, 1, 0, 0, 32'h0, 0};
    tv[13] = '{0, 0, 0, 1, 1, 0, 1, 32'h56, 2};
    tv[14] = '{1, 1, 0, 0, 0, 0, 0, 32'h0, 2};
    tv[15] = '{0, 0, 0, 0, 0, 0, 1, 32'h77, 0};
    tv[16] = '{0, 0, 0, 1, 1, 0, 0, 32'h0, 0};
    tv[17] = '{0, 0, 0, 1, 1, 1, 1, 32'hAB, 2};
    m0.adr = A0; m0.wdat = 32'h11; m0.sel = 4'h1;
    m1.adr = A1; m1.wdat = 32'h55; m1.sel = 4'h2;
    s.err = 1'b0;
    drv(1, 1, 0, 0, 0, 0, 1, 32'h41);
    #2 chk("rst_idle", 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drv(tv[i].c0, tv[i].s0, tv[i].w0, tv[i].c1, tv[i].s1, tv[i].w1, tv[i].ack, tv[i].sdat);
      #2 chk($sformatf("vec%0d", i), tv[i].own, 0, 0);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    drv(0, 0, 0, 1, 1, 0, 1, 32'hFF);
    #1 chk("rst_async", 0, 0, 0);
    @(negedge clk);
    drv(1, 1, 0, 1, 1, 0, 0, 32'h0);
    rst = 1'b0;
    #2 chk("rst_release", 0, 0, 0);
    @(negedge clk);
    #2 chk("tie_m0", 1, 0, 0);
    m0.cyc = 1'b0; m0.stb = 1'b0;
    @(negedge clk);
    #2 chk("gap_idle", 0, 0, 0);
    @(negedge clk);
    #2 chk("then_m1", 2, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    drv(1, 1, 0, 1, 1, 0, 0, 32'h0);
    #2 chk("idle_again", 0, 0, 0);
    @(negedge clk);
    #2 chk("tie_m0_again", 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    drv(1, 1, 0, 0, 0, 0, 0, 32'h0);
`ifdef UART_ARB_WATCHDOG_EN
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      #2 chk($sformatf("wd_cyc%0d", i), 1, i == 8, 0);
    end
    m0.cyc = 1'b0; m0.stb = 1'b0;
    @(negedge clk);
    #2 chk("wd_release", 0, 0, 0);
`else
    begin
      int bad = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        #2 if (m0.err !== 1'b0 || s.cyc !== 1'b1 || s.stb !== 1'b1 || s.adr !== A0) bad++;
      end
      n++;
      if (bad != 0) begin
        nbad++;
        $display("FAIL no_watchdog: %0d bad cycles, want 0", bad);
      end
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, nbad);
    $finish;
  end
endmodule
